// File: rtl/preif_pc_gen_pkg.sv
// Shared types and defaults for the pre-IF next-PC generator.
// The state encoding and redirect select are common to the top and the bench-visible interface.
package preif_pc_gen_pkg;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } preif_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

    // Redirect sources, listed from highest to lowest priority.
    localparam int unsigned REDIR_NUM = 4;

    typedef enum logic [REDIR_NUM-1:0] {
        RedirNone   = 4'b0000,
        RedirExcep  = 4'b0001,
        RedirErtn   = 4'b0010,
        RedirBranch = 4'b0100,
        RedirIdle   = 4'b1000
    } redir_sel_e;

endpackage

// File: rtl/preif_group_align.sv
// Fetch-group arithmetic: aligned base, per-slot PCs, slot mask and next sequential group.
// Purely combinational; the low two PC bits ride along so IF can flag misaligned targets.
module preif_group_align
    import preif_pc_gen_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned FETCH_WIDTH = 2
) (
    input  logic [PC_WIDTH-1:0]             i_pc,
    input  logic                            i_valid,
    output logic [PC_WIDTH*FETCH_WIDTH-1:0] o_slot_pc,
    output logic [FETCH_WIDTH-1:0]          o_slot_valid,
    output logic [PC_WIDTH-1:0]             o_seq_next
);

    localparam int unsigned        GROUP_BYTES = FETCH_WIDTH * 4;
    localparam logic [PC_WIDTH-1:0] GROUP_MASK = PC_WIDTH'(GROUP_BYTES - 1);
    localparam logic [PC_WIDTH-1:0] LOW_MASK   = PC_WIDTH'(3);

    logic [PC_WIDTH-1:0] w_base;
    logic [PC_WIDTH-1:0] w_off;
    logic [PC_WIDTH-1:0] w_low;

    assign w_base = i_pc & ~GROUP_MASK;
    // Slot index of the entry PC inside its group; always zero for single-wide fetch.
    assign w_off  = (i_pc & GROUP_MASK) >> 2;
    assign w_low  = i_pc & LOW_MASK;

    always_comb begin
        o_slot_pc    = '0;
        o_slot_valid = '0;
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            o_slot_pc[i*PC_WIDTH +: PC_WIDTH] = (w_base + PC_WIDTH'(4 * i)) | w_low;
            o_slot_valid[i]                   = i_valid & (PC_WIDTH'(i) >= w_off);
        end
    end

    assign o_seq_next = w_base + PC_WIDTH'(GROUP_BYTES);

endmodule

// File: rtl/preif_pc_gen.sv
// Pre-IF next-PC generator: owns the fetch PC, arbitrates redirects and hands IF one
// aligned fetch group per accepted cycle.
module preif_pc_gen
    import preif_pc_gen_pkg::*;
#(
    parameter int unsigned         PC_WIDTH    = 32,
    parameter int unsigned         FETCH_WIDTH = 2,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            next_allowin_i,
    output logic                            now_to_next_valid_o,
    output logic [PC_WIDTH*FETCH_WIDTH-1:0] pc_o,
    output logic [FETCH_WIDTH-1:0]          slot_valid_o,
    output logic                            flush_o,
    input  logic                            excep_en_i,
    input  logic [PC_WIDTH-1:0]             excep_pc_i,
    input  logic                            ertn_en_i,
    input  logic [PC_WIDTH-1:0]             ertn_pc_i,
    input  logic                            branch_en_i,
    input  logic [PC_WIDTH-1:0]             branch_pc_i,
    input  logic                            idle_en_i,
    input  logic [PC_WIDTH-1:0]             idle_pc_i
);

    preif_state_e        r_state;
    preif_state_e        w_state_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic [PC_WIDTH-1:0] w_tgt;
    logic [PC_WIDTH-1:0] w_seq_next;
    redir_sel_e          w_sel;
    logic                w_redir;
    logic                w_valid;
    logic                w_fire;

    // Only exception entry may wake the block from HALT; BOOT ignores every source.
    always_comb begin
        w_sel = RedirNone;
        case (r_state)
            StRun: begin
                if (excep_en_i) begin
                    w_sel = RedirExcep;
                end else if (ertn_en_i) begin
                    w_sel = RedirErtn;
                end else if (branch_en_i) begin
                    w_sel = RedirBranch;
                end else if (idle_en_i) begin
                    w_sel = RedirIdle;
                end
            end
            StHalt: begin
                if (excep_en_i) begin
                    w_sel = RedirExcep;
                end
            end
            default: w_sel = RedirNone;
        endcase
    end

    always_comb begin
        w_tgt = r_pc;
        unique case (w_sel)
            RedirExcep:  w_tgt = excep_pc_i;
            RedirErtn:   w_tgt = ertn_pc_i;
            RedirBranch: w_tgt = branch_pc_i;
            RedirIdle:   w_tgt = idle_pc_i;
            default:     w_tgt = r_pc;
        endcase
    end

    assign w_redir = (w_sel != RedirNone);
    assign w_valid = (r_state == StRun) & ~w_redir;
    assign w_fire  = w_valid & next_allowin_i;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            StBoot: w_state_next = StRun;
            StRun: begin
                // A redirect is taken even when IF is stalled so a one-cycle pulse is never lost.
                if (w_redir) begin
                    w_pc_next = w_tgt;
                    if (w_sel == RedirIdle) begin
                        w_state_next = StHalt;
                    end
                end else if (w_fire) begin
                    w_pc_next = w_seq_next;
                end
            end
            StHalt: begin
                if (w_redir) begin
                    w_pc_next    = w_tgt;
                    w_state_next = StRun;
                end
            end
            default: begin
                w_state_next = StBoot;
                w_pc_next    = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StBoot;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    preif_group_align #(
        .PC_WIDTH    (PC_WIDTH),
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_group_align (
        .i_pc         (r_pc),
        .i_valid      (w_valid),
        .o_slot_pc    (pc_o),
        .o_slot_valid (slot_valid_o),
        .o_seq_next   (w_seq_next)
    );

    assign now_to_next_valid_o = w_valid;
    assign flush_o             = w_redir;

endmodule

// File: tb/tb_preif_pc_gen.sv
// Scoreboard bench for preif_pc_gen: 2-wide and 4-wide instances share one stimulus stream
// and are checked against an arithmetic reference model of the fetch-PC behaviour.
module tb_preif_pc_gen;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;
    localparam int MODE_BOOT = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_HALT = 2;

    logic        clk;
    logic        rst_n;
    logic        allowin;
    logic        excep_en, ertn_en, branch_en, idle_en;
    logic [31:0] excep_pc, ertn_pc, branch_pc, idle_pc;

    logic         w_valid2, w_flush2;
    logic [63:0]  w_pc2;
    logic [1:0]   w_sv2;
    logic         w_valid4, w_flush4;
    logic [127:0] w_pc4;
    logic [3:0]   w_sv4;

    typedef struct {
        logic         valid;
        logic         flush;
        logic [63:0]  pc2;
        logic [1:0]   sv2;
        logic [127:0] pc4;
        logic [3:0]   sv4;
    } exp_t;

    exp_t sb[$];

    int          vectors    = 0;
    int          miscompares = 0;
    int          m_mode;
    logic [31:0] m_pc2, m_pc4;

    preif_pc_gen #(.PC_WIDTH(32), .FETCH_WIDTH(2), .RESET_PC(RST_PC)) dut2 (
        .clk                 (clk),
        .rst_n               (rst_n),
        .next_allowin_i      (allowin),
        .now_to_next_valid_o (w_valid2),
        .pc_o                (w_pc2),
        .slot_valid_o        (w_sv2),
        .flush_o             (w_flush2),
        .excep_en_i          (excep_en),
        .excep_pc_i          (excep_pc),
        .ertn_en_i           (ertn_en),
        .ertn_pc_i           (ertn_pc),
        .branch_en_i         (branch_en),
        .branch_pc_i         (branch_pc),
        .idle_en_i           (idle_en),
        .idle_pc_i           (idle_pc)
    );

    preif_pc_gen #(.PC_WIDTH(32), .FETCH_WIDTH(4), .RESET_PC(RST_PC)) dut4 (
        .clk                 (clk),
        .rst_n               (rst_n),
        .next_allowin_i      (allowin),
        .now_to_next_valid_o (w_valid4),
        .pc_o                (w_pc4),
        .slot_valid_o        (w_sv4),
        .flush_o             (w_flush4),
        .excep_en_i          (excep_en),
        .excep_pc_i          (excep_pc),
        .ertn_en_i           (ertn_en),
        .ertn_pc_i           (ertn_pc),
        .branch_en_i         (branch_en),
        .branch_pc_i         (branch_pc),
        .idle_en_i           (idle_en),
        .idle_pc_i           (idle_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: group of width fw containing pc, slots in increasing address order.
    function automatic logic [127:0] model_pcs(logic [31:0] pc, int fw);
        logic [127:0] r;
        logic [31:0]  base;
        int unsigned  gb;
        gb   = fw * 4;
        base = pc - (pc % gb);
        r    = '0;
        for (int i = 0; i < fw; i++) r[i*32 +: 32] = base + 32'(4 * i) + (pc % 4);
        return r;
    endfunction

    function automatic logic [3:0] model_mask(logic [31:0] pc, int fw, logic valid);
        logic [3:0]  m;
        int unsigned off;
        off = (pc % (fw * 4)) / 4;
        m   = '0;
        for (int i = 0; i < fw; i++) m[i] = valid && (i >= off);
        return m;
    endfunction

    function automatic logic [31:0] model_seq(logic [31:0] pc, int fw);
        return 32'(pc - (pc % (fw * 4)) + fw * 4);
    endfunction

    // One clock cycle: predict this cycle's outputs, queue them, then advance the model.
    task automatic step();
        logic        redir, to_halt;
        logic [31:0] tgt;
        exp_t        e;
        redir   = 1'b0;
        to_halt = 1'b0;
        tgt     = '0;
        if (m_mode == MODE_RUN) begin
            if (excep_en)       begin redir = 1'b1; tgt = excep_pc;  end
            else if (ertn_en)   begin redir = 1'b1; tgt = ertn_pc;   end
            else if (branch_en) begin redir = 1'b1; tgt = branch_pc; end
            else if (idle_en)   begin redir = 1'b1; tgt = idle_pc; to_halt = 1'b1; end
        end else if (m_mode == MODE_HALT && excep_en) begin
            redir = 1'b1;
            tgt   = excep_pc;
        end
        e.valid = (m_mode == MODE_RUN) && !redir;
        e.flush = redir;
        e.pc2   = 64'(model_pcs(m_pc2, 2));
        e.sv2   = 2'(model_mask(m_pc2, 2, e.valid));
        e.pc4   = model_pcs(m_pc4, 4);
        e.sv4   = model_mask(m_pc4, 4, e.valid);
        sb.push_back(e);
        @(posedge clk);
        if (m_mode == MODE_BOOT) begin
            m_mode = MODE_RUN;
        end else if (redir) begin
            m_pc2  = tgt;
            m_pc4  = tgt;
            m_mode = to_halt ? MODE_HALT : MODE_RUN;
        end else if (e.valid && allowin) begin
            m_pc2 = model_seq(m_pc2, 2);
            m_pc4 = model_seq(m_pc4, 4);
        end
        #1;
    endtask

    task automatic clear_redir();
        excep_en  = 1'b0;
        ertn_en   = 1'b0;
        branch_en = 1'b0;
        idle_en   = 1'b0;
    endtask

    // Redirects are held high during reset; the block must still show nothing.
    task automatic reset_seq();
        rst_n     = 1'b0;
        excep_en  = 1'b1;
        branch_en = 1'b1;
        @(negedge clk);
        check("rst_valid2", 128'(w_valid2), 128'(1'b0));
        check("rst_flush2", 128'(w_flush2), 128'(1'b0));
        check("rst_valid4", 128'(w_valid4), 128'(1'b0));
        check("rst_flush4", 128'(w_flush4), 128'(1'b0));
        @(posedge clk);
        #1;
        clear_redir();
        rst_n  = 1'b1;
        m_mode = MODE_BOOT;
        m_pc2  = RST_PC;
        m_pc4  = RST_PC;
    endtask

    function automatic logic [31:0] rand_tgt();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            1:       return $urandom;
            default: return 32'h1c00_0000 | (32'($urandom_range(0, 16'hFFFF)) & ~32'h3);
        endcase
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("valid2", 128'(w_valid2), 128'(e.valid));
                check("valid4", 128'(w_valid4), 128'(e.valid));
                check("flush2", 128'(w_flush2), 128'(e.flush));
                check("flush4", 128'(w_flush4), 128'(e.flush));
                check("slot_valid2", 128'(w_sv2), 128'(e.sv2));
                check("slot_valid4", 128'(w_sv4), 128'(e.sv4));
                if (e.valid) begin
                    check("pc2", 128'(w_pc2), 128'(e.pc2));
                    check("pc4", w_pc4, e.pc4);
                end
            end
        end
    end

    initial begin : driver
        allowin   = 1'b1;
        excep_pc  = '0;
        ertn_pc   = '0;
        branch_pc = '0;
        idle_pc   = '0;
        clear_redir();
        #2;
        reset_seq();

        // Boot cycle, then sequential groups with a 3-cycle stall on the second one.
        step();
        step();
        allowin = 1'b0;
        repeat (3) step();
        allowin = 1'b1;
        step();
        step();

        // Branch pulse while IF is stalled.
        allowin   = 1'b0;
        branch_en = 1'b1;
        branch_pc = 32'h1c00_0104;
        step();
        clear_redir();
        step();
        allowin = 1'b1;
        step();

        // Three sources at once: exception wins.
        excep_en  = 1'b1; excep_pc  = 32'h1c00_1000;
        ertn_en   = 1'b1; ertn_pc   = 32'h1c00_2000;
        branch_en = 1'b1; branch_pc = 32'h1c00_3000;
        step();
        clear_redir();
        step();
        step();

        // Idle into HALT, branch ignored, exception wakes it.
        idle_en = 1'b1;
        idle_pc = 32'h1c00_0020;
        step();
        clear_redir();
        step();
        branch_en = 1'b1;
        step();
        clear_redir();
        excep_en = 1'b1;
        excep_pc = 32'h1c00_8000;
        step();
        clear_redir();
        step();
        step();

        // Exception with idle stays in RUN.
        excep_en = 1'b1; excep_pc = 32'h1c00_4000;
        idle_en  = 1'b1; idle_pc  = 32'h1c00_5000;
        step();
        clear_redir();
        step();

        // Top-of-space group and silent wrap.
        branch_en = 1'b1;
        branch_pc = 32'hFFFF_FFF4;
        step();
        clear_redir();
        repeat (3) step();

        // Misaligned target carries its low bits.
        branch_en = 1'b1;
        branch_pc = 32'h1c00_0002;
        step();
        clear_redir();
        repeat (2) step();

        // Reset mid-stream; boot cycle ignores a pending branch.
        reset_seq();
        branch_en = 1'b1;
        branch_pc = 32'h1c00_0400;
        step();
        clear_redir();
        repeat (2) step();

        for (int n = 0; n < 2000; n++) begin
            allowin   = ($urandom_range(0, 3) != 0);
            excep_en  = ($urandom_range(0, 19) == 0);
            ertn_en   = ($urandom_range(0, 19) == 0);
            branch_en = ($urandom_range(0, 7) == 0);
            idle_en   = ($urandom_range(0, 24) == 0);
            excep_pc  = rand_tgt();
            ertn_pc   = rand_tgt();
            branch_pc = rand_tgt();
            idle_pc   = rand_tgt();
            if ($urandom_range(0, 299) == 0) reset_seq();
            else step();
        end
        clear_redir();
        step();

        @(negedge clk);
        #1;
        check("sb_drain", 128'(sb.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
